input_conditioner: RTL and testbench

- Parametrised, multi-channel conditioner for raw board inputs such as push-buttons and switches.
- Per channel: synchronises the input, filters it with a counter-based debounce, and produces a stable level plus one-cycle rise and fall pulses.
- Sits between the board pins and the rvsteel reset/halt/GPIO inputs in board top levels.
- Replaces single-flop "debouncing" with a real filter whose width, depth and channel count are configurable.

---
 rtl/input_conditioner_pkg.sv | 26 ++
 rtl/input_conditioner_channel.sv | 123 ++++++++++++
 rtl/input_conditioner.sv | 46 ++++
 tb/tb_input_conditioner.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared constants and helpers for the input conditioner: counter sizing and default
// debounce/long-press cycle counts derived from the board clock.
package input_conditioner_pkg;

    localparam int unsigned CLOCK_FREQUENCY = 50_000_000;

    // 10 ms debounce window and 1 s long-press hold at CLOCK_FREQUENCY.
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = CLOCK_FREQUENCY / 100;
    localparam int unsigned DEFAULT_LONG_PRESS_CYCLES = CLOCK_FREQUENCY;

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
        logic long_hit;
    } channel_status_t;

    // Bits needed to hold values 0..max_count; never narrower than one bit.
    function automatic int unsigned counter_width(input int unsigned max_count);
        if (max_count < 1) begin
            return 1;
        end
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/input_conditioner_channel.sv
// One conditioner lane: synchroniser, counter debounce, registered edge pulses and, when
// INPUT_CONDITIONER_LONG_PRESS_EN is defined, a hold counter producing a long-press pulse.
module input_conditioner_channel
    import input_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES       = 2,
    parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic        INIT_LEVEL        = 1'b0,
    parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            raw_in,
    output channel_status_t status
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if (LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long_press
        $error("LONG_PRESS_CYCLES must exceed DEBOUNCE_CYCLES");
    end

    localparam int unsigned CW = counter_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] COUNT_ONE      = CW'(1);
    localparam logic [CW-1:0] COUNT_TERMINAL = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [CW-1:0]          count_q, count_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   flip;
    logic                   long_hit;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= {SYNC_STAGES{INIT_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
        end
    end

    // Any cycle where sync agrees with the stable level discards the partial count.
    always_comb begin
        count_d = '0;
        level_d = level_q;
        flip    = 1'b0;
        if (sync != level_q) begin
            if (count_q == COUNT_TERMINAL) begin
                flip    = 1'b1;
                level_d = sync;
            end else begin
                count_d = count_q + COUNT_ONE;
            end
        end
        rise_d = flip & sync;
        fall_d = flip & ~sync;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            level_q <= INIT_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
    localparam int unsigned HW = counter_width(LONG_PRESS_CYCLES);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          long_q, long_d;

    // Cleared on the edge that raises the level, so the count restarts with each press;
    // parking at HOLD_MAX makes the pulse fire once until a fall re-arms it.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (!level_q || flip) begin
            hold_d = '0;
        end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HOLD_ONE;
            long_d = (hold_q == HOLD_LAST);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_hit = long_q;
`else
    assign long_hit = 1'b0;
`endif

    assign status.level    = level_q;
    assign status.rise     = rise_q;
    assign status.fall     = fall_q;
    assign status.long_hit = long_hit;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel conditioner for board buttons/switches: one independent debounce lane per
// input. Long-press pulses exist only when INPUT_CONDITIONER_LONG_PRESS_EN is defined.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int unsigned          CHANNELS          = 2,
    parameter int unsigned          SYNC_STAGES       = 2,
    parameter int unsigned          DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic [CHANNELS-1:0]  INIT_LEVEL        = '0,
    parameter int unsigned          LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] raw_in,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic [CHANNELS-1:0] long_press
);

    if (CHANNELS < 1) begin : g_bad_channels
        $error("CHANNELS must be at least 1");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
        channel_status_t status;

        input_conditioner_channel #(
            .SYNC_STAGES      (SYNC_STAGES),
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .INIT_LEVEL       (INIT_LEVEL[i]),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
        ) u_channel (
            .clock (clock),
            .reset (reset),
            .raw_in(raw_in[i]),
            .status(status)
        );

        assign level_out[i]  = status.level;
        assign rise_pulse[i] = status.rise;
        assign fall_pulse[i] = status.fall;
        assign long_press[i] = status.long_hit;
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed scenarios with literal expectations,
// then random bouncing inputs compared every cycle against a window-based reference model.
module tb_input_conditioner;

    localparam int unsigned CH = 2;
    localparam int unsigned SS = 2;
    localparam int unsigned DB = 4;
    localparam int unsigned LP = 10;
    localparam logic [CH-1:0] INIT = 2'b00;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [CH-1:0] raw_in = '0;
    logic [CH-1:0] level_out, rise_pulse, fall_pulse, long_press;

    always #5 clock = ~clock;

    input_conditioner #(
        .CHANNELS         (CH),
        .SYNC_STAGES      (SS),
        .DEBOUNCE_CYCLES  (DB),
        .INIT_LEVEL       (INIT),
        .LONG_PRESS_CYCLES(LP)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .raw_in    (raw_in),
        .level_out (level_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .long_press(long_press)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at time %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sync is raw delayed by SS edges; the level flips once the last DB
    // synced samples since the previous flip all disagree with it.
    logic [CH-1:0] exp_level, exp_rise, exp_fall, exp_long;
    logic          sq  [CH][$];
    logic          win [CH][$];
    int            edge_n;
    int            rise_edge [CH];
    bit            model_ready = 1'b0;

    always @(posedge clock or negedge reset) begin
        logic s;
        bit   all_diff;
        bit   long_now;
        if (!reset) begin
            edge_n = 0;
            for (int c = 0; c < CH; c++) begin
                sq[c].delete();
                win[c].delete();
                for (int k = 0; k < SS; k++) sq[c].push_back(INIT[c]);
                rise_edge[c] = 0;
            end
            exp_level = INIT;
            exp_rise  = '0;
            exp_fall  = '0;
            exp_long  = '0;
        end else begin
            edge_n++;
            for (int c = 0; c < CH; c++) begin
                s = sq[c].pop_front();
                sq[c].push_back(raw_in[c]);
                win[c].push_back(s);
                if (win[c].size() > DB) void'(win[c].pop_front());
                all_diff = (win[c].size() == DB);
                for (int k = 0; k < win[c].size(); k++) begin
                    if (win[c][k] == exp_level[c]) all_diff = 1'b0;
                end
                long_now = exp_level[c] && !all_diff && ((edge_n - rise_edge[c]) == LP);
                exp_rise[c] = all_diff && s;
                exp_fall[c] = all_diff && !s;
                if (all_diff) begin
                    exp_level[c] = s;
                    win[c].delete();
                    if (s) rise_edge[c] = edge_n;
                end
`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
                exp_long[c] = long_now;
`else
                exp_long[c] = 1'b0;
`endif
            end
        end
    end

    always @(negedge clock) begin
        if (model_ready) begin
            check("model_level", level_out, exp_level);
            check("model_rise", rise_pulse, exp_rise);
            check("model_fall", fall_pulse, exp_fall);
            check("model_long", long_press, exp_long);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int left [CH];

    initial begin
        #1 reset = 1'b0;
        model_ready = 1'b1;
        raw_in = 2'b11;
        repeat (3) tick();
        check("reset_level", level_out, 2'b00);
        check("reset_rise", rise_pulse, 2'b00);
        check("reset_long", long_press, 2'b00);

        // Release with inputs differing from INIT: no pulse at release, full latency.
        reset = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check("release_level_hold", level_out, 2'b00);
            check("release_no_pulse", rise_pulse | fall_pulse, 2'b00);
        end
        tick();
        check("release_level_edge6", level_out, 2'b11);
        check("release_rise_edge6", rise_pulse, 2'b11);

        // Channel 0 release: fall after 6 edges, channel 1 untouched.
        raw_in = 2'b10;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check("fall_level_hold", level_out, 2'b11);
        end
        tick();
        check("fall_level_edge6", level_out, 2'b10);
        check("fall_pulse_edge6", fall_pulse, 2'b01);
        check("fall_no_rise", rise_pulse, 2'b00);

        // Bounce on channel 0: high 3, low 1, then steady high; flip at edge 10.
        raw_in = 2'b11;
        repeat (3) tick();
        raw_in = 2'b10;
        tick();
        raw_in = 2'b11;
        for (int e = 5; e <= 9; e++) begin
            tick();
            check("bounce_level_hold", level_out, 2'b10);
            check("bounce_no_rise", rise_pulse, 2'b00);
        end
        tick();
        check("bounce_level_edge10", level_out, 2'b11);
        check("bounce_rise_edge10", rise_pulse, 2'b01);
        tick();
        check("bounce_rise_once", rise_pulse, 2'b00);

        // Reset two mismatch cycles into a debounce, then re-observe full latency.
        raw_in = 2'b00;
        repeat (4) tick();
        check("midreset_before", level_out, 2'b11);
        reset = 1'b0;
        #1;
        check("midreset_level", level_out, 2'b00);
        check("midreset_pulses", rise_pulse | fall_pulse | long_press, 2'b00);
        raw_in = 2'b11;
        tick();
        reset = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check("midreset_release_hold", level_out, 2'b00);
        end
        tick();
        check("midreset_release_edge6", level_out, 2'b11);
        check("midreset_release_rise", rise_pulse, 2'b11);

        // Hold both high: long-press exactly 10 edges after the level rose, then quiet.
        for (int e = 1; e <= 9; e++) begin
            tick();
            check("long_before", long_press, 2'b00);
        end
        tick();
`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
        check("long_at_10", long_press, 2'b11);
`else
        check("long_disabled", long_press, 2'b00);
`endif
        for (int e = 1; e <= 15; e++) begin
            tick();
            check("long_after", long_press, 2'b00);
        end

        // Random bouncing with short glitches, long holds and occasional resets.
        for (int c = 0; c < CH; c++) left[c] = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            for (int c = 0; c < CH; c++) begin
                if (left[c] == 0) begin
                    raw_in[c] = ~raw_in[c];
                    left[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(8, 30)
                                                          : $urandom_range(1, 5);
                end else begin
                    left[c]--;
                end
            end
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b0;
                repeat (2) tick();
                reset = 1'b1;
            end
        end

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
